// File: rtl/demux3to8_p_pkg.sv
// Shared types and constants for the 3-to-8 line reconstruction demux.
// FSM states, idle output pattern, and encoder flag-pair encodings {Yex, Ys}.
package demux3to8_p_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] DOUT_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        ILLEGAL  = 2'b00,
        VALID    = 2'b01,
        EMPTY    = 2'b10,
        DISABLED = 2'b11
    } flags_t;

    // Code 0 drives dout[7] low, code 7 drives dout[0] low.
    function automatic logic [7:0] line_low(input logic [2:0] code);
        logic [7:0] pat;
        pat = DOUT_IDLE;
        pat[3'd7 - code] = 1'b0;
        return pat;
    endfunction

endpackage

// File: rtl/demux3to8_p_hold_tmr.sv
// Load/decrement hold timer; flags the final hold cycle and saturates at zero.
module hold_tmr #(
    parameter int CNT_W    = 3,
    parameter int LOAD_VAL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: clear beats load beats decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= CNT_W'(LOAD_VAL);
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/demux3to8_p.sv
// Rebuilds one-hot-low lines from an 8-to-3 priority encoder's code and flags.
// Optional macro DEMUX_RETRIG_EN allows a new valid code to retrigger during HOLD.
module demux3to8_p
    import demux3to8_p_pkg::*;
#(
    parameter int HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [2:0] din,
    input  logic       Ys,
    input  logic       Yex,
    input  logic       in_vld,
    output logic       in_rdy,
    output logic [7:0] dout,
    output logic       busy,
    output logic       err
);

    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    state_t     state_r;
    logic [7:0] dout_r;
    logic       busy_r;
    logic       err_r;

    flags_t     flags_s;
    logic       in_rdy_s;
    logic       xfer_s;
    logic       tmr_load_s;
    logic       tmr_dec_s;
    logic       tmr_last_s;

    assign flags_s = flags_t'({Yex, Ys});

    // Ready qualification; with retrigger the block also listens while holding.
    always_comb begin
        in_rdy_s = 1'b0;
        if (rst || sel) begin
            in_rdy_s = 1'b0;
        end else begin
`ifdef DEMUX_RETRIG_EN
            in_rdy_s = (state_r == IDLE) || (state_r == HOLD);
`else
            in_rdy_s = (state_r == IDLE);
`endif
        end
    end

    // Timer controls derived from the current transfer and state.
    always_comb begin
        xfer_s     = in_vld && in_rdy_s;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        if (xfer_s && (flags_s == VALID)) begin
            tmr_load_s = 1'b1;
        end else begin
            tmr_dec_s = (state_r == HOLD);
        end
    end

    hold_tmr #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (HOLD_CYC)
    ) u_hold_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (sel),
        .load (tmr_load_s),
        .dec  (tmr_dec_s),
        .last (tmr_last_s)
    );

    // Main FSM with registered line, busy and sticky error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            dout_r  <= DOUT_IDLE;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (sel) begin
            state_r <= IDLE;
            dout_r  <= DOUT_IDLE;
            busy_r  <= 1'b0;
            err_r   <= err_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s && (flags_s == VALID)) begin
                        state_r <= HOLD;
                        dout_r  <= line_low(din);
                        busy_r  <= 1'b1;
                        err_r   <= err_r;
                    end else if (xfer_s && (flags_s == ILLEGAL)) begin
                        state_r <= IDLE;
                        dout_r  <= DOUT_IDLE;
                        busy_r  <= 1'b0;
                        err_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        dout_r  <= DOUT_IDLE;
                        busy_r  <= 1'b0;
                        err_r   <= err_r;
                    end
                end
                HOLD: begin
                    // A transfer here only happens in the retrigger build.
                    err_r <= (xfer_s && (flags_s == ILLEGAL)) ? 1'b1 : err_r;
                    if (tmr_load_s) begin
                        state_r <= HOLD;
                        dout_r  <= line_low(din);
                        busy_r  <= 1'b1;
                    end else if (tmr_last_s) begin
                        state_r <= GAP;
                        dout_r  <= DOUT_IDLE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= HOLD;
                        dout_r  <= dout_r;
                        busy_r  <= 1'b1;
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                    dout_r  <= DOUT_IDLE;
                    busy_r  <= 1'b0;
                    err_r   <= err_r;
                end
                default: begin
                    state_r <= IDLE;
                    dout_r  <= DOUT_IDLE;
                    busy_r  <= 1'b0;
                    err_r   <= err_r;
                end
            endcase
        end
    end

    assign in_rdy = in_rdy_s;
    assign dout   = dout_r;
    assign busy   = busy_r;
    assign err    = err_r;

endmodule

// File: tb/tb_demux3to8_p.sv
// Directed bench for demux3to8_p: time-remaining reference model checked every cycle,
// plus literal expectations on key cycles.
module tb_demux3to8_p;

    localparam int HC = 4;
`ifdef DEMUX_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       sel;
    logic [2:0] din;
    logic       Ys;
    logic       Yex;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] dout;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Reference model: how many line cycles / gap cycles remain.
    int m_hold = 0;
    int m_gap  = 0;
    int m_code = 0;
    bit m_err  = 1'b0;

    demux3to8_p #(.HOLD_CYC(HC)) dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .din    (din),
        .Ys     (Ys),
        .Yex    (Yex),
        .in_vld (in_vld),
        .in_rdy (in_rdy),
        .dout   (dout),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        if (rst || sel) return 1'b0;
        if (m_hold == 0 && m_gap == 0) return 1'b1;
        return RETRIG && (m_hold > 0);
    endfunction

    function automatic logic [7:0] model_dout();
        logic [7:0] one;
        one = 8'd1;
        if (m_hold > 0) return 8'hFF ^ (one << (7 - m_code));
        return 8'hFF;
    endfunction

    // Model update on each rising edge from the inputs held over the cycle.
    always @(posedge clk) begin
        bit xfer;
        xfer = in_vld && model_rdy();
        if (rst) begin
            m_hold = 0; m_gap = 0; m_err = 1'b0;
        end else if (sel) begin
            m_hold = 0; m_gap = 0;
        end else begin
            if (xfer && !Yex && !Ys) m_err = 1'b1;
            if (xfer && !Yex && Ys) begin
                m_code = int'(din); m_hold = HC; m_gap = 0;
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_gap = 1;
            end else if (m_gap > 0) begin
                m_gap--;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_dout",  dout, model_dout());
            chk("m_busy",  {7'd0, busy},   {7'd0, (m_hold > 0) || (m_gap > 0)});
            chk("m_err",   {7'd0, err},    {7'd0, m_err});
            chk("m_in_rdy", {7'd0, in_rdy}, {7'd0, model_rdy()});
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] c, input logic yex, input logic ys);
        din = c; Yex = yex; Ys = ys; in_vld = 1'b1;
        tick(1);
        in_vld = 1'b0; Yex = 1'b1; Ys = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_rdy && k < 20) begin
            tick(1);
            k++;
        end
        chk("rdy_timeout", {7'd0, in_rdy}, 8'd1);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b1; din = 3'd0; Yex = 1'b1; Ys = 1'b1; in_vld = 1'b0;
        tick(2);
        check_en = 1'b1;
        chk("rst_dout", dout, 8'hFF);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_err",  {7'd0, err},  8'd0);
        chk("rst_rdy",  {7'd0, in_rdy}, 8'd0);

        rst = 1'b0; sel = 1'b0;
        tick(1);
        chk("idle_rdy", {7'd0, in_rdy}, 8'd1);

        // Code 2: four cycles of dout[5] low, one gap cycle, then ready.
        send(3'b010, 1'b0, 1'b1);
        chk("c2_first", dout, 8'b11011111);
        chk("c2_busy",  {7'd0, busy}, 8'd1);
        tick(3);
        chk("c2_fourth", dout, 8'b11011111);
        tick(1);
        chk("c2_gap", dout, 8'hFF);
        chk("c2_gap_busy", {7'd0, busy}, 8'd1);
        tick(1);
        chk("c2_back_rdy", {7'd0, in_rdy}, 8'd1);

        // Boundary codes 000 and 111.
        send(3'b000, 1'b0, 1'b1);
        chk("c0_line", dout, 8'b01111111);
        tick(3);
        chk("c0_fourth", dout, 8'b01111111);
        wait_idle();
        send(3'b111, 1'b0, 1'b1);
        chk("c7_line", dout, 8'b11111110);
        wait_idle();

        // Empty and disabled flag pairs leave the outputs idle.
        send(3'd5, 1'b1, 1'b0);
        chk("empty_dout", dout, 8'hFF);
        send(3'd5, 1'b1, 1'b1);
        chk("dis_busy", {7'd0, busy}, 8'd0);

        // Illegal pair: sticky err, later valid transfers still work.
        send(3'd3, 1'b0, 1'b0);
        chk("ill_err",  {7'd0, err}, 8'd1);
        chk("ill_dout", dout, 8'hFF);
        tick(1);
        send(3'd4, 1'b0, 1'b1);
        chk("c4_line", dout, 8'b11110111);
        chk("err_sticky", {7'd0, err}, 8'd1);
        wait_idle();

        // sel high on the second HOLD cycle aborts the line.
        send(3'd1, 1'b0, 1'b1);
        tick(1);
        sel = 1'b1;
        tick(1);
        chk("sel_dout", dout, 8'hFF);
        chk("sel_busy", {7'd0, busy}, 8'd0);
        sel = 1'b0;
        tick(1);
        chk("sel_rdy", {7'd0, in_rdy}, 8'd1);

        // Transfer attempt with sel high is ignored.
        sel = 1'b1;
        send(3'd3, 1'b0, 1'b1);
        chk("sel_ign", dout, 8'hFF);
        sel = 1'b0;
        tick(1);

        // Reset mid-HOLD.
        send(3'd6, 1'b0, 1'b1);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("mrst_dout", dout, 8'hFF);
        chk("mrst_busy", {7'd0, busy}, 8'd0);
        chk("mrst_err",  {7'd0, err},  8'd0);
        rst = 1'b0;
        tick(1);

`ifdef DEMUX_RETRIG_EN
        // Retrigger on the third HOLD cycle: new line for four full cycles, no gap.
        send(3'd2, 1'b0, 1'b1);
        tick(2);
        send(3'd5, 1'b0, 1'b1);
        chk("rt_line", dout, 8'b11111011);
        tick(3);
        chk("rt_fourth", dout, 8'b11111011);
        tick(1);
        chk("rt_gap", dout, 8'hFF);
        wait_idle();
`endif

        tick(2);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
